seven_seg_scan_controller: RTL and testbench
============================================

// Module: seven_seg_scan_controller
// PURPOSE
//   Drives the 4-digit multiplexed 7-segment display for the reaction-time tester.
//   Accepts a binary result (ms) on a load strobe and converts it to 4 BCD digits
//   with an iterative double-dabble FSM. It then time-multiplexes the digits onto
//   the shared seg/an lines. Sits between the reaction-timer core and the pad
//   mapping (seg -> uo_out[7:1], an -> uio_out[3:0]).
// PARAMETERS
//   REFRESH_DIV  50000  clk cycles each digit is lit before advancing (>=2)
//   SEG_ACT_LOW  1      1: seg outputs active-low; 0: active-high
//   AN_ACT_LOW   1      1: an outputs active-low; 0: active-high
// PORTS
//   clk       in   1   system clock; all state on rising edge
//   reset     in   1   synchronous, active-high reset
//   value_in  in   14  binary value to display; sampled only on an accepted load
//   load      in   1   1-cycle strobe; accepted only when busy=0
//   blank_lz  in   1   1: blank leading zeros (digit 0 always lit)
//   blank     in   1   1: all anodes inactive (display dark)
//   busy      out  1   1 while a conversion is in progress
//   seg       out  7   segments, seg[0]=a .. seg[6]=g; registered
//   an        out  4   digit enables, an[0]=rightmost (ones); registered
// BEHAVIOUR
//   Reset: state=IDLE, busy=0, digit reg=0000, refresh cnt=0, digit idx=0;
//     seg/an = all inactive (SEG_ACT_LOW=1: seg=7'h7F; AN_ACT_LOW=1: an=4'hF).
//   Saturation: value_in>9999 is clamped to 9999 at capture.
//   FSM states:
//   - IDLE: load=1 -> capture clamped value into shift reg, clear BCD scratch,
//     iter=0, go CONVERT.
//   - CONVERT: 14 cycles, one double-dabble step each. Each BCD nibble >=5
//     gets +3, then {bcd,bin} shifts left by 1. Go COMMIT after iter 13.
//   - COMMIT: copy BCD scratch into digit reg in one cycle, go IDLE.
//   Latency: load accepted at edge k -> busy=1 after edge k through edge k+15.
//     Digit reg is updated at edge k+15. busy=0 after edge k+15.
//   load while busy=1 (CONVERT or COMMIT) is ignored; no queueing.
//   The display keeps showing the old digit reg during conversion (no tearing).
//   Scanner runs every cycle, independent of the FSM:
//   - refresh cnt counts 0..REFRESH_DIV-1. On wrap, digit idx advances
//     0->1->2->3->0.
//   - seg/an are registered from the current idx; they lag idx by 1 cycle.
//   - Exactly one anode is active per cycle, unless that digit is blanked.
//   Blanking (blank anode inactive; seg outputs the inactive pattern):
//   - blank=1 blanks every digit.
//   - blank_lz=1 blanks digit i>0 when digits i..3 are all zero.
//   - Value 0 therefore shows a single '0' on digit 0.
//   Segment map, active-high gfedcba: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.
//     Inverted when SEG_ACT_LOW=1.
//   Reset mid-conversion: aborts, digit reg=0000, busy=0 next cycle.
//   Reset has priority over load.
//   Simultaneous load and reset: reset wins; value is discarded.
// TESTING (REFRESH_DIV=4, active-low polarity)
//   1 reset, blank=0, blank_lz=0 -> an=F, seg=7F, busy=0 on the first post-reset
//     cycle; thereafter the scan shows 0000 and digit 0 shows seg=40.
//   2 load 1234 -> busy high exactly 15 cycles. Then the scan shows
//     an=E/seg=19, an=D/seg=30, an=B/seg=24, an=7/seg=79, 4 cycles each, repeating.
//   3 load 12000 -> all four digits show 9 (seg=10); load 9999 gives the same.
//   4 blank_lz=1: load 7 -> only an=E ever active, seg=78;
//     load 0 -> only an=E, seg=40; load 1005 -> 1,0,0,5 all lit.
//   5 load 1234; load 5678 at busy cycle 5 -> ignored, 1234 shown.
//     Then load 4321 and reset at busy cycle 8 -> busy=0, digits 0000.
//   6 blank=1 during load 42 -> an=F throughout; conversion still completes.
//     blank=0 -> 0042 shown.

Source files
------------

// File: rtl/seven_seg_scan_controller.sv
// 4-digit multiplexed 7-segment driver: clamps a 14-bit binary value, converts it
// to BCD with an iterative double-dabble FSM, and scans the digits onto seg/an.
module seven_seg_scan_controller #(
    parameter int REFRESH_DIV = 50000,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit AN_ACT_LOW  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] value_in,
    input  logic        load,
    input  logic        blank_lz,
    input  logic        blank,
    output logic        busy,
    output logic [6:0]  seg,
    output logic [3:0]  an
);
    localparam int CNT_W = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_COMMIT} state_t;

    state_t          state, state_nxt;
    logic [13:0]     bin_sr;
    logic [15:0]     bcd, bcd_adj;
    logic [3:0]      iter;
    logic [15:0]     digits;
    logic [13:0]     value_clamped;

    logic [CNT_W-1:0] refresh_cnt;
    logic [1:0]       idx;
    logic [3:0]       cur_digit;
    logic             lz_blank, dark;
    logic [6:0]       seg_hi;
    logic [3:0]       an_hi;

    assign value_clamped = (value_in > 14'd9999) ? 14'd9999 : value_in;
    assign busy          = (state != S_IDLE);

    // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
    for (genvar i = 0; i < 4; i++) begin : g_adj
        assign bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3
                                                           : bcd[4*i +: 4];
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (load) state_nxt = S_CONVERT;
            S_CONVERT: if (iter == 4'd13) state_nxt = S_COMMIT;
            S_COMMIT:  state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bin_sr <= '0;
            bcd    <= '0;
            iter   <= '0;
            digits <= '0;
        end else begin
            case (state)
                S_IDLE: if (load) begin
                    bin_sr <= value_clamped;
                    bcd    <= '0;
                    iter   <= '0;
                end
                S_CONVERT: begin
                    {bcd, bin_sr} <= {bcd_adj[14:0], bin_sr, 1'b0};
                    iter          <= iter + 4'd1;
                end
                S_COMMIT: digits <= bcd;
                default: ;
            endcase
        end
    end

    // Scanner runs free of the FSM; display only ever sees committed digits.
    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt <= '0;
            idx         <= '0;
        end else if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            idx         <= idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    assign cur_digit = digits[{idx, 2'b00} +: 4];

    always_comb begin
        lz_blank = 1'b0;
        case (idx)
            2'd1:    lz_blank = (digits[15:4]  == 12'd0);
            2'd2:    lz_blank = (digits[15:8]  == 8'd0);
            2'd3:    lz_blank = (digits[15:12] == 4'd0);
            default: lz_blank = 1'b0;
        endcase
    end

    assign dark = blank | (blank_lz & lz_blank);

    always_comb begin
        seg_hi = 7'h00;
        case (cur_digit)
            4'd0: seg_hi = 7'h3F;
            4'd1: seg_hi = 7'h06;
            4'd2: seg_hi = 7'h5B;
            4'd3: seg_hi = 7'h4F;
            4'd4: seg_hi = 7'h66;
            4'd5: seg_hi = 7'h6D;
            4'd6: seg_hi = 7'h7D;
            4'd7: seg_hi = 7'h07;
            4'd8: seg_hi = 7'h7F;
            4'd9: seg_hi = 7'h6F;
            default: seg_hi = 7'h00;
        endcase
    end

    assign an_hi = dark ? 4'b0000 : (4'b0001 << idx);

    // Outputs are built active-high, then XOR'd into the pad polarity.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg <= {7{SEG_ACT_LOW}};
            an  <= {4{AN_ACT_LOW}};
        end else begin
            seg <= (dark ? 7'h00 : seg_hi) ^ {7{SEG_ACT_LOW}};
            an  <= an_hi ^ {4{AN_ACT_LOW}};
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// Directed bench for seven_seg_scan_controller: REFRESH_DIV=4, active-low outputs.
module tb_seven_seg_scan_controller;
    logic        clk = 1'b0;
    logic        reset, load, blank_lz, blank;
    logic [13:0] value_in;
    logic        busy;
    logic [6:0]  seg;
    logic [3:0]  an;

    int checks = 0;
    int errors = 0;

    seven_seg_scan_controller #(.REFRESH_DIV(4), .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1)) dut (
        .clk(clk), .reset(reset), .value_in(value_in), .load(load),
        .blank_lz(blank_lz), .blank(blank), .busy(busy), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    typedef struct {
        string           name;
        logic [13:0]     value;
        logic            blz;
        logic [3:0][6:0] segs;   // [3]=thousands .. [0]=ones, active-low
        logic [3:0]      lit;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Observe one full scan period (16 cycles) and check every lit digit.
    task automatic check_scan(input string nm, input logic [3:0][6:0] segs, input logic [3:0] lit);
        int cnt[4];
        int j;
        for (int k = 0; k < 4; k++) cnt[k] = 0;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (an == 4'hF) begin
                chk({nm, " dark_seg"}, int'(seg), 'h7F);
            end else begin
                chk({nm, " an_onehot"}, $countones(~an), 1);
                j = 0;
                for (int b = 3; b >= 0; b--) if (!an[b]) j = b;
                chk({nm, " seg_digit"}, int'(seg), int'(segs[j]));
                cnt[j]++;
            end
        end
        for (int k = 0; k < 4; k++)
            chk({nm, " lit_cycles"}, cnt[k], lit[k] ? 4 : 0);
    endtask

    task automatic load_and_wait(input logic [13:0] v, output int nbusy);
        value_in = v; load = 1'b1;
        tick();
        load = 1'b0; nbusy = 0;
        while (busy && nbusy < 40) begin nbusy++; tick(); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0] = '{"v1234",  14'd1234,  1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF};
        vecs[1] = '{"v12000", 14'd12000, 1'b0, {7'h10, 7'h10, 7'h10, 7'h10}, 4'hF};
        vecs[2] = '{"v9999",  14'd9999,  1'b0, {7'h10, 7'h10, 7'h10, 7'h10}, 4'hF};
        vecs[3] = '{"lz7",    14'd7,     1'b1, {7'h40, 7'h40, 7'h40, 7'h78}, 4'h1};
        vecs[4] = '{"lz0",    14'd0,     1'b1, {7'h40, 7'h40, 7'h40, 7'h40}, 4'h1};
        vecs[5] = '{"lz1005", 14'd1005,  1'b1, {7'h79, 7'h40, 7'h40, 7'h12}, 4'hF};
        vecs[6] = '{"lz42",   14'd42,    1'b1, {7'h40, 7'h40, 7'h19, 7'h24}, 4'h3};
        vecs[7] = '{"v0",     14'd0,     1'b0, {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF};

        reset = 1'b1; load = 1'b0; blank = 1'b0; blank_lz = 1'b0; value_in = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_an", int'(an), 'hF);
        chk("rst_seg", int'(seg), 'h7F);
        chk("rst_busy", int'(busy), 0);
        tick();
        chk("first_an", int'(an), 'hE);
        chk("first_seg", int'(seg), 'h40);
        check_scan("rst_scan", {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF);

        for (int i = 0; i < 8; i++) begin
            blank_lz = vecs[i].blz;
            load_and_wait(vecs[i].value, n);
            chk({vecs[i].name, " busy_len"}, n, 15);
            check_scan(vecs[i].name, vecs[i].segs, vecs[i].lit);
        end
        blank_lz = 1'b0;

        // Load while busy is ignored.
        value_in = 14'd1234; load = 1'b1;
        tick();
        load = 1'b0; n = 0;
        while (busy && n < 40) begin
            n++;
            if (n == 5) begin value_in = 14'd5678; load = 1'b1; end
            else load = 1'b0;
            tick();
        end
        load = 1'b0;
        chk("ign_busy_len", n, 15);
        chk("ign_busy_after", int'(busy), 0);
        check_scan("ign_1234", {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF);

        // Reset mid-conversion, with a simultaneous load that must be discarded.
        value_in = 14'd4321; load = 1'b1;
        tick();
        load = 1'b0; n = 0;
        while (busy && n < 40) begin
            n++;
            if (n == 8) break;
            tick();
        end
        chk("abort_reached", n, 8);
        reset = 1'b1; load = 1'b1; value_in = 14'd9999;
        tick();
        reset = 1'b0; load = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_an", int'(an), 'hF);
        tick();
        chk("abort_busy2", int'(busy), 0);
        check_scan("abort_0000", {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF);

        // Global blank holds the display dark while conversion completes.
        blank = 1'b1;
        value_in = 14'd42; load = 1'b1;
        tick();
        load = 1'b0; n = 0;
        while (busy && n < 40) begin
            chk("blank_an_busy", int'(an), 'hF);
            n++;
            tick();
        end
        chk("blank_busy_len", n, 15);
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("blank_an_idle", int'(an), 'hF);
        end
        blank = 1'b0;
        check_scan("unblank_0042", {7'h40, 7'h40, 7'h19, 7'h24}, 4'hF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
